// File: rtl/enigma_pkg.sv
// Shared alphabet, notch and settle constants plus the keystroke FSM state type
// for the Enigma keystroke controller and its helpers.
package enigma_pkg;

    localparam int ALPHA  = 26;
    localparam int NOTCH0 = 16;
    localparam int NOTCH1 = 4;
    localparam int SETTLE = 1;

    typedef logic [4:0] letter_t;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DRIVE,
        OUT
    } state_t;

    // Out-of-alphabet start positions collapse to 0 rather than wrapping.
    function automatic letter_t clamp_letter(letter_t v, letter_t alpha);
        return (v < alpha) ? v : '0;
    endfunction

endpackage

// File: rtl/enigma_keystroke_ctrl_if.sv
// Bundles the key input, load, rotor path and cipher output signals of the
// keystroke controller; slave is the controller side, master its environment.
interface enigma_keystroke_ctrl_if;
    import enigma_pkg::*;

    logic    load_en;
    letter_t load_pos0;
    letter_t load_pos1;
    letter_t load_pos2;
    logic    key_valid;
    letter_t key_in;
    logic    key_ready;
    letter_t pos0;
    letter_t pos1;
    letter_t pos2;
    letter_t path_out;
    letter_t path_in;
    logic    cipher_valid;
    letter_t cipher_out;
    logic    cipher_ready;
    logic    key_err;

    modport slave (
        input  load_en, load_pos0, load_pos1, load_pos2,
        input  key_valid, key_in, path_in, cipher_ready,
        output key_ready, pos0, pos1, pos2, path_out,
        output cipher_valid, cipher_out, key_err
    );

    modport master (
        output load_en, load_pos0, load_pos1, load_pos2,
        output key_valid, key_in, path_in, cipher_ready,
        input  key_ready, pos0, pos1, pos2, path_out,
        input  cipher_valid, cipher_out, key_err
    );

endinterface

// File: rtl/enigma_keystroke_ctrl_step.sv
// Combinational Enigma odometer: next rotor positions from the current ones,
// including the rotor1 double step at its own notch.
module rotor_step_logic
    import enigma_pkg::*;
#(
    parameter int ALPHA  = enigma_pkg::ALPHA,
    parameter int NOTCH0 = enigma_pkg::NOTCH0,
    parameter int NOTCH1 = enigma_pkg::NOTCH1
) (
    input  letter_t pos0,
    input  letter_t pos1,
    input  letter_t pos2,
    output letter_t nxt_pos0,
    output letter_t nxt_pos1,
    output letter_t nxt_pos2
);

    localparam letter_t LAST = letter_t'(ALPHA - 1);
    localparam letter_t N0   = letter_t'(NOTCH0);
    localparam letter_t N1   = letter_t'(NOTCH1);

    logic r1_step;
    logic r2_step;

    function automatic letter_t wrap_inc(letter_t p);
        return (p == LAST) ? '0 : p + letter_t'(1);
    endfunction

    // rotor1 sitting on its notch drags itself and rotor2 along (double step).
    assign r1_step  = (pos0 == N0) || (pos1 == N1);
    assign r2_step  = (pos1 == N1);

    assign nxt_pos0 = wrap_inc(pos0);
    assign nxt_pos1 = r1_step ? wrap_inc(pos1) : pos1;
    assign nxt_pos2 = r2_step ? wrap_inc(pos2) : pos2;

endmodule

// File: rtl/enigma_keystroke_ctrl.sv
// Keystroke sequencer: accepts a letter, steps the rotors, drives the rotor path,
// waits for it to settle and hands the returned letter out on a valid/ready port.
module enigma_keystroke_ctrl
    import enigma_pkg::*;
#(
    parameter int ALPHA  = enigma_pkg::ALPHA,
    parameter int NOTCH0 = enigma_pkg::NOTCH0,
    parameter int NOTCH1 = enigma_pkg::NOTCH1,
    parameter int SETTLE = enigma_pkg::SETTLE
) (
    input logic                    clk,
    input logic                    rst,
    enigma_keystroke_ctrl_if.slave bus
);

    localparam letter_t ALPHA_L = letter_t'(ALPHA);
    localparam int      CNT_W   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

    state_t           state;
    state_t           state_nxt;
    letter_t          pos0_q;
    letter_t          pos1_q;
    letter_t          pos2_q;
    letter_t          path_q;
    letter_t          cipher_q;
    logic             key_err_q;
    logic [CNT_W-1:0] settle_cnt;
    letter_t          step_pos0;
    letter_t          step_pos1;
    letter_t          step_pos2;
    logic             key_ready_w;
    logic             accept_w;
    logic             key_ok_w;
    logic             settle_done_w;

    assign key_ready_w   = (state == IDLE) && !bus.load_en;
    assign accept_w      = bus.key_valid && key_ready_w;
    assign key_ok_w      = bus.key_in < ALPHA_L;
    assign settle_done_w = (settle_cnt == '0);

    rotor_step_logic #(
        .ALPHA  (ALPHA),
        .NOTCH0 (NOTCH0),
        .NOTCH1 (NOTCH1)
    ) u_step (
        .pos0     (pos0_q),
        .pos1     (pos1_q),
        .pos2     (pos2_q),
        .nxt_pos0 (step_pos0),
        .nxt_pos1 (step_pos1),
        .nxt_pos2 (step_pos2)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept_w && key_ok_w) state_nxt = STEP;
            STEP:    state_nxt = DRIVE;
            DRIVE:   if (settle_done_w) state_nxt = OUT;
            OUT:     if (bus.cipher_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Positions move only on a load in IDLE or the single STEP edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos0_q     <= '0;
            pos1_q     <= '0;
            pos2_q     <= '0;
            path_q     <= '0;
            cipher_q   <= '0;
            key_err_q  <= 1'b0;
            settle_cnt <= '0;
        end else begin
            key_err_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.load_en) begin
                        pos0_q <= clamp_letter(bus.load_pos0, ALPHA_L);
                        pos1_q <= clamp_letter(bus.load_pos1, ALPHA_L);
                        pos2_q <= clamp_letter(bus.load_pos2, ALPHA_L);
                    end else if (accept_w && key_ok_w) begin
                        path_q <= bus.key_in;
                    end else if (accept_w) begin
                        key_err_q <= 1'b1;
                    end
                end
                STEP: begin
                    pos0_q     <= step_pos0;
                    pos1_q     <= step_pos1;
                    pos2_q     <= step_pos2;
                    settle_cnt <= SETTLE_LAST;
                end
                DRIVE: begin
                    if (settle_done_w) cipher_q   <= bus.path_in;
                    else               settle_cnt <= settle_cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.key_ready    = key_ready_w;
    assign bus.pos0         = pos0_q;
    assign bus.pos1         = pos1_q;
    assign bus.pos2         = pos2_q;
    assign bus.path_out     = path_q;
    assign bus.cipher_valid = (state == OUT);
    assign bus.cipher_out   = cipher_q;
    assign bus.key_err      = key_err_q;

endmodule
